// File: rtl/inst_issue_queue_pkg.sv
// Shared defaults, field widths and flush-mode encoding for the instruction issue queue.
package inst_issue_queue_pkg;

    localparam int IQ_DEPTH   = 16;
    localparam int IQ_FETCH_W = 2;
    localparam int IQ_ISSUE_W = 2;
    localparam int IQ_INST_W  = 32;
    localparam int IQ_PC_W    = 32;

    typedef enum logic [0:0] {
        FlushAll    = 1'b0,
        FlushKeepDs = 1'b1
    } flush_mode_e;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the issue queue, including pop clamping
// and the flush / keep-delay-slot pointer selection.
module iq_ptr_ctrl
    import inst_issue_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int ISSUE_W = IQ_ISSUE_W,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int IC_W    = $clog2(ISSUE_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               keep_ds_i,
    input  logic [FETCH_W-1:0] push_valid_i,
    input  logic [IC_W-1:0]    issue_cnt_i,
    output logic [PTR_W-1:0]   head_o,
    output logic [PTR_W-1:0]   tail_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               push_en_o,
    output logic               ds_from_mem_o,
    output logic               ds_from_push_o,
    output logic [PTR_W-1:0]   ds_idx_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pop_n, push_n, push_acc, remain;
    flush_mode_e      flush_mode;

    assign full_o     = count_q > CNT_W'(DEPTH - FETCH_W);
    assign push_en_o  = !full_o && !flush_i;
    assign flush_mode = keep_ds_i ? FlushKeepDs : FlushAll;
    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign count_o    = count_q;

    always_comb begin
        push_n = '0;
        for (int l = 0; l < FETCH_W; l++) begin
            push_n = push_n + CNT_W'(push_valid_i[l]);
        end
        push_acc = full_o ? '0 : push_n;
        pop_n    = (CNT_W'(issue_cnt_i) > count_q) ? count_q : CNT_W'(issue_cnt_i);
        remain   = count_q - pop_n;
        ds_idx_o = head_q + PTR_W'(pop_n);

        ds_from_mem_o  = 1'b0;
        ds_from_push_o = 1'b0;
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_acc);
        count_d = count_q - pop_n + push_acc;

        // The surviving delay slot is relocated to slot 0 so the restarted queue is contiguous.
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (flush_mode == FlushKeepDs) begin
                if (remain != '0) begin
                    ds_from_mem_o = 1'b1;
                    tail_d        = PTR_W'(1);
                    count_d       = CNT_W'(1);
                end else if (push_valid_i[0] && !full_o) begin
                    ds_from_push_o = 1'b1;
                    tail_d         = PTR_W'(1);
                    count_d        = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/inst_issue_queue.sv
// Circular multi-port instruction FIFO between fetch and the decoders: storage,
// write-lane steering and the oldest-first read muxes.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int ISSUE_W = IQ_ISSUE_W,
    parameter int INST_W  = IQ_INST_W,
    parameter int PC_W    = IQ_PC_W,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         keep_ds_i,
    input  logic [FETCH_W-1:0]           push_valid_i,
    input  logic [FETCH_W*INST_W-1:0]    push_inst_i,
    input  logic [FETCH_W*PC_W-1:0]      push_pc_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [CNT_W-1:0]             count_o,
    output logic [ISSUE_W-1:0]           issue_valid_o,
    output logic [ISSUE_W*INST_W-1:0]    issue_inst_o,
    output logic [ISSUE_W*PC_W-1:0]      issue_pc_o,
    input  logic [$clog2(ISSUE_W+1)-1:0] issue_cnt_i
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];

    logic [PTR_W-1:0] head, tail, ds_idx;
    logic             push_en, ds_from_mem, ds_from_push;

    iq_ptr_ctrl #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .PTR_W   (PTR_W),
        .CNT_W   (CNT_W)
    ) u_ptr_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .keep_ds_i      (keep_ds_i),
        .push_valid_i   (push_valid_i),
        .issue_cnt_i    (issue_cnt_i),
        .head_o         (head),
        .tail_o         (tail),
        .count_o        (count_o),
        .full_o         (full_o),
        .push_en_o      (push_en),
        .ds_from_mem_o  (ds_from_mem),
        .ds_from_push_o (ds_from_push),
        .ds_idx_o       (ds_idx)
    );

    assign empty_o = (count_o == '0);

    // Valid lanes are contiguous from lane 0, so lane l lands at tail+l.
    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        for (int l = 0; l < FETCH_W; l++) begin
            if (push_en && push_valid_i[l]) begin
                inst_mem_d[tail + PTR_W'(l)] = push_inst_i[l*INST_W +: INST_W];
                pc_mem_d[tail + PTR_W'(l)]   = push_pc_i[l*PC_W +: PC_W];
            end
        end
        if (ds_from_mem) begin
            inst_mem_d[0] = inst_mem_q[ds_idx];
            pc_mem_d[0]   = pc_mem_q[ds_idx];
        end else if (ds_from_push) begin
            inst_mem_d[0] = push_inst_i[INST_W-1:0];
            pc_mem_d[0]   = push_pc_i[PC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_issue
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx           = head + PTR_W'(k);
        assign issue_valid_o[k] = count_o > CNT_W'(k);
        assign issue_inst_o[k*INST_W +: INST_W] = issue_valid_o[k] ? inst_mem_q[rd_idx] : '0;
        assign issue_pc_o[k*PC_W +: PC_W]       = issue_valid_o[k] ? pc_mem_q[rd_idx]   : '0;
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Randomised and directed self-checking bench for inst_issue_queue against a queue-based model.
module tb_inst_issue_queue;

    localparam int DEPTH   = 16;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int INST_W  = 32;
    localparam int PC_W    = 32;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int IC_W    = $clog2(ISSUE_W + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic                      clk;
    logic                      rst;
    logic                      flush_i;
    logic                      keep_ds_i;
    logic [FETCH_W-1:0]        push_valid_i;
    logic [FETCH_W*INST_W-1:0] push_inst_i;
    logic [FETCH_W*PC_W-1:0]   push_pc_i;
    logic                      full_o;
    logic                      empty_o;
    logic [CNT_W-1:0]          count_o;
    logic [ISSUE_W-1:0]        issue_valid_o;
    logic [ISSUE_W*INST_W-1:0] issue_inst_o;
    logic [ISSUE_W*PC_W-1:0]   issue_pc_o;
    logic [IC_W-1:0]           issue_cnt_i;

    entry_t model_q[$];
    int     checkCount = 0;
    int     errCount   = 0;

    inst_issue_queue #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .INST_W  (INST_W),
        .PC_W    (PC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .keep_ds_i     (keep_ds_i),
        .push_valid_i  (push_valid_i),
        .push_inst_i   (push_inst_i),
        .push_pc_i     (push_pc_i),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .count_o       (count_o),
        .issue_valid_o (issue_valid_o),
        .issue_inst_o  (issue_inst_o),
        .issue_pc_o    (issue_pc_o),
        .issue_cnt_i   (issue_cnt_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fetch must present a valid mask contiguous from lane 0; occupancy may never exceed DEPTH.
    always @(posedge clk) begin
        assert (((push_valid_i + 1'b1) & push_valid_i) == '0)
            else $error("[TB] non-contiguous push_valid_i %b", push_valid_i);
        assert (count_o <= CNT_W'(DEPTH))
            else $error("[TB] count_o %0d exceeds depth", count_o);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compareAll();
        int                 sz;
        logic [ISSUE_W-1:0] expValid;
        logic [INST_W-1:0]  expInst;
        logic [PC_W-1:0]    expPc;
        sz = model_q.size();
        checkOutput("count", 64'(count_o), 64'(sz));
        checkOutput("empty", 64'(empty_o), 64'(sz == 0));
        checkOutput("full", 64'(full_o), 64'((DEPTH - sz) < FETCH_W));
        for (int k = 0; k < ISSUE_W; k++) expValid[k] = (sz > k);
        checkOutput("valid", 64'(issue_valid_o), 64'(expValid));
        for (int k = 0; k < ISSUE_W; k++) begin
            expInst = (sz > k) ? model_q[k].inst : '0;
            expPc   = (sz > k) ? model_q[k].pc   : '0;
            checkOutput($sformatf("inst%0d", k), 64'(issue_inst_o[k*INST_W +: INST_W]), 64'(expInst));
            checkOutput($sformatf("pc%0d", k), 64'(issue_pc_o[k*PC_W +: PC_W]), 64'(expPc));
        end
    endtask

    // Reference behaviour: occupancy is just the list length; flush keeps at most one entry.
    task automatic modelStep();
        int     popN;
        bit     fullNow;
        entry_t ds;
        entry_t lane;
        fullNow = (DEPTH - model_q.size()) < FETCH_W;
        popN = int'(issue_cnt_i);
        if (popN > model_q.size()) popN = model_q.size();
        for (int i = 0; i < popN; i++) void'(model_q.pop_front());
        if (flush_i) begin
            if (keep_ds_i && model_q.size() > 0) begin
                ds = model_q[0];
                model_q.delete();
                model_q.push_back(ds);
            end else if (keep_ds_i && push_valid_i[0] && !fullNow) begin
                lane.inst = push_inst_i[INST_W-1:0];
                lane.pc   = push_pc_i[PC_W-1:0];
                model_q.delete();
                model_q.push_back(lane);
            end else begin
                model_q.delete();
            end
        end else if (!fullNow) begin
            for (int l = 0; l < FETCH_W; l++) begin
                if (push_valid_i[l]) begin
                    lane.inst = push_inst_i[l*INST_W +: INST_W];
                    lane.pc   = push_pc_i[l*PC_W +: PC_W];
                    model_q.push_back(lane);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic kd, input logic [FETCH_W-1:0] pv,
                                 input logic [IC_W-1:0] ic, input logic [PC_W-1:0] pcBase);
        flush_i      = fl;
        keep_ds_i    = kd;
        push_valid_i = pv;
        issue_cnt_i  = ic;
        for (int l = 0; l < FETCH_W; l++) begin
            push_inst_i[l*INST_W +: INST_W] = INST_W'($urandom);
            push_pc_i[l*PC_W +: PC_W]       = pcBase + PC_W'(4 * l);
        end
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Pulses reset between clock edges; the queue must empty without waiting for a clock.
    task automatic doAsyncReset();
        push_valid_i = '0;
        flush_i      = 1'b0;
        issue_cnt_i  = '0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        compareAll();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [FETCH_W-1:0] pv;
        rst          = 1'b1;
        flush_i      = 1'b0;
        keep_ds_i    = 1'b0;
        push_valid_i = '0;
        push_inst_i  = '0;
        push_pc_i    = '0;
        issue_cnt_i  = '0;
        #12;
        rst = 1'b0;
        compareAll();

        // Fill to DEPTH, then an extra push must be ignored.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, PC_W'(32'h1000 + 8 * i));
        checkOutput("fill_count", 64'(count_o), 64'd16);
        checkOutput("fill_full", 64'(full_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, 32'h2000);
        checkOutput("fill_ignored", 64'(count_o), 64'd16);

        // Pop request larger than occupancy is clamped.
        doAsyncReset();
        applyStimulus(1'b0, 1'b0, 2'b01, 2'd0, 32'h40);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'd2, 32'h0);
        checkOutput("clamp_empty", 64'(empty_o), 64'd1);
        checkOutput("clamp_valid", 64'(issue_valid_o), 64'd0);

        // Move head/tail to 14 and stream across the wrap boundary.
        doAsyncReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, PC_W'(32'h3000 + 8 * i));
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 2'b00, 2'd2, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, 32'hBFC00000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, 2'd2, 32'hBFC00000 + PC_W'(8 * (i + 1)));
            checkOutput("wrap_pc0", 64'(issue_pc_o[PC_W-1:0]), 64'(32'hBFC00000 + 8 * (i + 1)));
            checkOutput("wrap_count", 64'(count_o), 64'd2);
        end

        // Flush-all with a concurrent push.
        doAsyncReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, PC_W'(32'h500 + 8 * i));
        applyStimulus(1'b1, 1'b0, 2'b11, 2'd1, 32'h600);
        checkOutput("flushall_count", 64'(count_o), 64'd0);
        checkOutput("flushall_empty", 64'(empty_o), 64'd1);

        // Flush keeping the delay slot left after this cycle's pop.
        doAsyncReset();
        applyStimulus(1'b0, 1'b0, 2'b11, 2'd0, 32'h100);
        applyStimulus(1'b0, 1'b0, 2'b01, 2'd0, 32'h108);
        applyStimulus(1'b1, 1'b1, 2'b11, 2'd1, 32'h300);
        checkOutput("keepds_count", 64'(count_o), 64'd1);
        checkOutput("keepds_pc", 64'(issue_pc_o[PC_W-1:0]), 64'h104);

        // Delay slot taken from push lane 0 on an empty queue, then async reset.
        doAsyncReset();
        applyStimulus(1'b1, 1'b1, 2'b01, 2'd0, 32'h200);
        checkOutput("keeppush_count", 64'(count_o), 64'd1);
        checkOutput("keeppush_pc", 64'(issue_pc_o[PC_W-1:0]), 64'h200);
        doAsyncReset();
        checkOutput("arst_count", 64'(count_o), 64'd0);
        checkOutput("arst_pc", 64'(issue_pc_o), 64'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       pv = 2'b00;
                1:       pv = 2'b01;
                default: pv = 2'b11;
            endcase
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom), pv,
                          IC_W'($urandom_range(0, ISSUE_W)), PC_W'($urandom) & 32'hFFFF_FFF8);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
